// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
//
// Serial-to-parallel front end. Framed serial bits, qualified by bit_valid,
// are assembled into a WIDTH-bit word. Each completed word is placed on
// parallel_out together with a one-cycle out_valid strobe so the downstream
// parallel register can capture it. A frame_start seen while a frame is
// still in progress aborts that frame (frame_err pulse) and starts a new one
// with the current bit.
//
// Optional feature macro: PARITY_EN
//   When defined, every frame carries one extra even-parity bit after the
//   WIDTH data bits. The word is delivered on that bit together with
//   parity_err. When undefined, parity_err is tied to 0.
//
// Parameters:
//   WIDTH     - data word width in bits (>= 2)
//   MSB_FIRST - 1: first received bit lands in parallel_out[WIDTH-1]
//               0: first received bit lands in parallel_out[0]
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous active-low reset
//   serial_in    - serial data bit, sampled only when bit_valid = 1
//   bit_valid    - qualifies serial_in in the current cycle
//   frame_start  - current valid bit is the first bit of a frame
//   parallel_out - last completed word, held until the next completion
//   out_valid    - one-cycle pulse: parallel_out has just been updated
//   busy         - a frame is partially received
//   frame_err    - one-cycle pulse: a frame was aborted by frame_start
//   parity_err   - parity result, qualified by out_valid
// -----------------------------------------------------------------------------
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH) + 1;
    // Count value held while the last data bit is being captured.
    localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
`ifdef PARITY_EN
    localparam logic [CW-1:0] ALL_DATA  = CW'(WIDTH);
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef PARITY_EN
        ,
        PARITY = 2'd2
`endif
    } state_t;

    state_t          state_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] shreg_next;

    // One shift step in the configured bit order.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic             b);
        logic [WIDTH-1:0] res;
        if (MSB_FIRST) begin
            res = {cur[WIDTH-2:0], b};
        end else begin
            res = {b, cur[WIDTH-1:1]};
        end
        return res;
    endfunction

    assign shreg_next = shift_in(shreg_reg, serial_in);

`ifndef PARITY_EN
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            shreg_reg    <= '0;
            count_reg    <= '0;
            parallel_out <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            frame_err    <= 1'b0;
`ifdef PARITY_EN
            parity_err   <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            out_valid <= 1'b0;
            frame_err <= 1'b0;
`ifdef PARITY_EN
            parity_err <= 1'b0;
`endif
            if (bit_valid) begin
                if (frame_start) begin
                    // New frame from any state; a frame in progress is
                    // dropped. The old shift contents are cleared so the
                    // discarded bits can never leak into the new word.
                    frame_err <= (state_reg != IDLE);
                    shreg_reg <= shift_in('0, serial_in);
                    count_reg <= CW'(1);
                    state_reg <= SHIFT;
                    busy      <= 1'b1;
                end else begin
                    case (state_reg)
                        SHIFT: begin
                            shreg_reg <= shreg_next;
                            if (count_reg == LAST_DATA) begin
`ifdef PARITY_EN
                                count_reg <= ALL_DATA;
                                state_reg <= PARITY;
`else
                                parallel_out <= shreg_next;
                                out_valid    <= 1'b1;
                                count_reg    <= '0;
                                state_reg    <= IDLE;
                                busy         <= 1'b0;
`endif
                            end else begin
                                count_reg <= count_reg + 1'b1;
                            end
                        end
`ifdef PARITY_EN
                        PARITY: begin
                            // Even parity: data bits plus parity bit XOR to 0.
                            parallel_out <= shreg_reg;
                            out_valid    <= 1'b1;
                            parity_err   <= ^{shreg_reg, serial_in};
                            count_reg    <= '0;
                            state_reg    <= IDLE;
                            busy         <= 1'b0;
                        end
`endif
                        default: begin
                            // IDLE: bits outside a frame are ignored.
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// -----------------------------------------------------------------------------
// tb_sipo_deserializer
//
// Drives two deserializers (MSB-first and LSB-first) from the same serial
// stream. A frame-level model (a queue of received bits, word built with
// arithmetic) predicts every output each cycle; directed literal checks pin
// the delivered words, pulse counts and busy durations.
// -----------------------------------------------------------------------------
module tb_sipo_deserializer;

    localparam int W = 4;
`ifdef PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic serial_in = 1'b0;
    logic bit_valid = 1'b0;
    logic frame_start = 1'b0;

    logic [W-1:0] po_m, po_l;
    logic ov_m, ov_l, busy_m, busy_l, fe_m, fe_l, pe_m, pe_l;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .parallel_out(po_m), .out_valid(ov_m),
        .busy(busy_m), .frame_err(fe_m), .parity_err(pe_m)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .parallel_out(po_l), .out_valid(ov_l),
        .busy(busy_l), .frame_err(fe_l), .parity_err(pe_l)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    bit           mbits[$];
    logic [W-1:0] e_po_m = '0;
    logic [W-1:0] e_po_l = '0;
    logic         e_ov = 1'b0, e_busy = 1'b0, e_fe = 1'b0, e_pe = 1'b0;

    function automatic logic [W-1:0] word_of(input bit msb_first);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (mbits[i]) begin
                if (msb_first) w[W-1-i] = 1'b1;
                else           w[i]     = 1'b1;
            end
        end
        return w;
    endfunction

    // Event log for directed checks.
    int           cyc = 0;
    int           ov_count = 0;
    int           fe_count = 0;
    int           busy_cnt = 0;
    logic [W-1:0] last_m = '0;
    logic [W-1:0] last_l = '0;
    logic         last_pe = 1'b0;
    logic [W-1:0] words[$];
    int           ov_cyc[$];

    // Compare process: checks the current outputs, then advances the model
    // with the inputs that the next rising edge will sample.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            mbits.delete();
            e_po_m = '0; e_po_l = '0;
            e_ov = 1'b0; e_busy = 1'b0; e_fe = 1'b0; e_pe = 1'b0;
        end
        chk("po_msb",   32'(po_m),   32'(e_po_m));
        chk("po_lsb",   32'(po_l),   32'(e_po_l));
        chk("ov_msb",   32'(ov_m),   32'(e_ov));
        chk("ov_lsb",   32'(ov_l),   32'(e_ov));
        chk("busy_msb", 32'(busy_m), 32'(e_busy));
        chk("busy_lsb", 32'(busy_l), 32'(e_busy));
        chk("fe_msb",   32'(fe_m),   32'(e_fe));
        chk("fe_lsb",   32'(fe_l),   32'(e_fe));
        chk("pe_msb",   32'(pe_m & ov_m), 32'(e_pe));
        chk("pe_lsb",   32'(pe_l & ov_l), 32'(e_pe));

        if (ov_m) begin
            ov_count++;
            last_m  = po_m;
            last_l  = po_l;
            last_pe = pe_m;
            words.push_back(po_m);
            ov_cyc.push_back(cyc);
            $display("WORD cycle=%0d msb_first=%b lsb_first=%b parity_err=%b", cyc, po_m, po_l, pe_m);
        end
        if (fe_m) fe_count++;
        if (busy_m) busy_cnt++;

        if (reset) begin
            e_ov = 1'b0; e_fe = 1'b0; e_pe = 1'b0;
            if (bit_valid) begin
                if (frame_start) begin
                    e_fe = (mbits.size() != 0);
                    mbits.delete();
                    mbits.push_back(serial_in);
                end else if (mbits.size() != 0) begin
                    if (mbits.size() == W) begin
                        // Parity bit of a complete data word.
                        bit p;
                        p = serial_in;
                        foreach (mbits[i]) p ^= mbits[i];
                        e_po_m = word_of(1'b1);
                        e_po_l = word_of(1'b0);
                        e_ov = 1'b1;
                        e_pe = p;
                        mbits.delete();
                    end else begin
                        mbits.push_back(serial_in);
                        if (mbits.size() == W && PAR == 0) begin
                            e_po_m = word_of(1'b1);
                            e_po_l = word_of(1'b0);
                            e_ov = 1'b1;
                            mbits.delete();
                        end
                    end
                end
            end
            e_busy = (mbits.size() != 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic bit_in(input logic b, input logic fs);
        @(posedge clk); #1;
        serial_in = b; bit_valid = 1'b1; frame_start = fs;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            bit_valid = 1'b0; frame_start = 1'b0;
        end
    endtask

    // b[W-1] is sent first; gap idle cycles between bits.
    task automatic send_frame(input logic [W-1:0] b, input int gap);
        for (int i = W - 1; i >= 0; i--) begin
            bit_in(b[i], (i == W - 1));
            if (i > 0) idle(gap);
        end
`ifdef PARITY_EN
        idle(gap);
        bit_in(^b, 1'b0);
`endif
    endtask

    task automatic clr();
        ov_count = 0; fe_count = 0; busy_cnt = 0;
        words.delete(); ov_cyc.delete();
    endtask

    initial begin
        // Reset held for 2 cycles.
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk("reset_po",   32'(po_m),   32'h0);
        chk("reset_busy", 32'(busy_m), 32'h0);

        // Basic frame 1010.
        clr();
        send_frame(4'b1010, 0);
        idle(2);
        chk("basic_ov_count", 32'(ov_count), 32'd1);
        chk("basic_word",     32'(last_m),   32'hA);
        chk("basic_model",    32'(e_po_m),   32'hA);
        chk("basic_busy_len", 32'(busy_cnt), 32'(3 + PAR));
        chk("basic_fe",       32'(fe_count), 32'd0);

        // Gapped frame 0101, two idle cycles between bits.
        clr();
        send_frame(4'b0101, 2);
        idle(2);
        chk("gap_ov_count", 32'(ov_count), 32'd1);
        chk("gap_word",     32'(last_m),   32'h5);
        chk("gap_busy_len", 32'(busy_cnt), 32'((3 + PAR) * 3));

        // Abort after two bits, restart with 1111.
        clr();
        bit_in(1'b0, 1'b1);
        bit_in(1'b1, 1'b0);
        send_frame(4'b1111, 0);
        idle(2);
        chk("abort_fe_count", 32'(fe_count), 32'd1);
        chk("abort_ov_count", 32'(ov_count), 32'd1);
        chk("abort_word",     32'(last_m),   32'hF);

        // Back-to-back frames 1010 then 0011.
        clr();
        send_frame(4'b1010, 0);
        send_frame(4'b0011, 0);
        idle(2);
        chk("b2b_ov_count", 32'(ov_count), 32'd2);
        if (ov_count == 2) begin
            chk("b2b_word0",    32'(words[0]), 32'hA);
            chk("b2b_word1",    32'(words[1]), 32'h3);
            chk("b2b_interval", 32'(ov_cyc[1] - ov_cyc[0]), 32'(W + PAR));
        end
        chk("b2b_fe", 32'(fe_count), 32'd0);

        // Bit order: 1,0,0,0.
        clr();
        send_frame(4'b1000, 0);
        idle(2);
        chk("order_msb",       32'(last_m), 32'h8);
        chk("order_lsb",       32'(last_l), 32'h1);
        chk("order_model_lsb", 32'(e_po_l), 32'h1);

        // Reset in the middle of a frame.
        bit_in(1'b1, 1'b1);
        bit_in(1'b1, 1'b0);
        @(posedge clk); #1;
        bit_valid = 1'b0; frame_start = 1'b0; reset = 1'b0;
        #1;
        chk("midrst_po",   32'(po_m),   32'h0);
        chk("midrst_busy", 32'(busy_m), 32'h0);
        chk("midrst_ov",   32'(ov_m),   32'h0);
        chk("midrst_fe",   32'(fe_m),   32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        clr();
        send_frame(4'b1100, 0);
        idle(2);
        chk("postrst_word", 32'(last_m),   32'hC);
        chk("postrst_ov",   32'(ov_count), 32'd1);
        chk("postrst_fe",   32'(fe_count), 32'd0);

        // Stray inputs in IDLE: frame_start alone and bit_valid alone.
        clr();
        @(posedge clk); #1; frame_start = 1'b1; bit_valid = 1'b0; serial_in = 1'b1;
        @(posedge clk); #1; frame_start = 1'b0; bit_valid = 1'b1;
        @(posedge clk); #1; bit_valid = 1'b1; serial_in = 1'b0;
        idle(2);
        chk("stray_busy", 32'(busy_cnt), 32'd0);
        chk("stray_ov",   32'(ov_count), 32'd0);
        chk("stray_word", 32'(po_m),     32'hC);

`ifdef PARITY_EN
        // Good parity then bad parity on data 1010.
        clr();
        bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b0);
        bit_in(1'b0, 1'b0);
        idle(2);
        chk("par_ok_word", 32'(last_m),  32'hA);
        chk("par_ok_pe",   32'(last_pe), 32'd0);
        clr();
        bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        idle(2);
        chk("par_bad_word", 32'(last_m),   32'hA);
        chk("par_bad_pe",   32'(last_pe),  32'd1);
        chk("par_bad_ov",   32'(ov_count), 32'd1);
`endif

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
